// File: rtl/team_06_audio_pkg.sv
// Shared audio-path types for the team_06 playback chain.
//   sample_t       : one 8-bit unsigned audio sample
//   SAMPLE_SILENCE : mid-scale sample emitted whenever no real data exists
//   fifo_state_t   : playback buffer state (PRIME = filling, PLAY = draining)
package team_06_audio_pkg;

  typedef logic [7:0] sample_t;

  localparam sample_t SAMPLE_SILENCE = 8'h80;

  typedef enum logic {
    PRIME = 1'b0,
    PLAY  = 1'b1
  } fifo_state_t;

endpackage

// File: rtl/team_06_playback_fifo_if.sv
// Handshake bundle between the sample producer/consumer and the playback FIFO.
//   master : drives flush, wr_valid, wr_data, rd_req; observes the FIFO outputs
//   slave  : the FIFO itself; drives rd_data, rd_valid, level, playing,
//            overrun, underrun
interface team_06_playback_fifo_if #(
  parameter int AW = 4
) ();
  import team_06_audio_pkg::*;

  logic          flush;
  logic          wr_valid;
  sample_t       wr_data;
  logic          rd_req;
  sample_t       rd_data;
  logic          rd_valid;
  logic [AW:0]   level;
  logic          playing;
  logic          overrun;
  logic          underrun;

  modport master (
    output flush, wr_valid, wr_data, rd_req,
    input  rd_data, rd_valid, level, playing, overrun, underrun
  );

  modport slave (
    input  flush, wr_valid, wr_data, rd_req,
    output rd_data, rd_valid, level, playing, overrun, underrun
  );

endinterface

// File: rtl/team_06_sample_ram.sv
// DEPTH x 8 sample storage: one write port, one registered read port.
//   clk      : system clock
//   i_we     : write enable, stores i_wdata at i_waddr
//   i_waddr  : write address
//   i_wdata  : write data
//   i_re     : read enable, loads r_mem[i_raddr] into the output register
//   i_raddr  : read address
//   o_rdata  : registered read data; holds while i_re is low
// The array has no reset; contents are meaningless until written.
// A same-address read and write in one cycle returns the old contents.
module team_06_sample_ram
  import team_06_audio_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  sample_t       i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output sample_t       o_rdata
);

  sample_t r_mem [DEPTH];
  sample_t r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/team_06_playback_fifo.sv
// Elastic sample buffer between the ESP32 sample receiver and the I2S/DAC path.
// Holds playback until PRIME samples are buffered, substitutes SILENCE on
// underrun, and reports fill level plus overrun/underrun pulses.
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   bus.flush    : synchronous clear (pointers, level, state)
//   bus.wr_valid : one-cycle pulse, bus.wr_data is a new sample
//   bus.rd_req   : one-cycle pulse, consumer wants the next sample
//   bus.rd_data  : output sample, valid with bus.rd_valid
//   bus.rd_valid : one-cycle pulse, one cycle after rd_req
//   bus.level    : occupancy 0..DEPTH
//   bus.playing  : high in PLAY
//   bus.overrun  : one-cycle pulse, incoming sample dropped
//   bus.underrun : one-cycle pulse, read in PLAY found the buffer empty
//
// state | meaning
// PRIME | filling; reads return SILENCE, leave when level >= PRIME
// PLAY  | draining; reads pop samples, a read on empty returns to PRIME
module team_06_playback_fifo
  import team_06_audio_pkg::sample_t;
  import team_06_audio_pkg::fifo_state_t;
  import team_06_audio_pkg::SAMPLE_SILENCE;
#(
  parameter int      DEPTH   = 16,
  parameter int      AW      = 4,
  parameter int      PRIME   = 8,
  parameter sample_t SILENCE = SAMPLE_SILENCE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  team_06_playback_fifo_if.slave  bus
);

  localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] PRIME_LVL = (AW+1)'(PRIME);

  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_level;
  fifo_state_t   r_state;
  logic          r_rd_valid;
  logic          r_overrun;
  logic          r_underrun;
  logic          r_use_silence;

  logic          w_active;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_starve;
  logic [AW:0]   w_level_nxt;
  sample_t       w_ram_q;

  // Reset and flush both suppress every side effect of the cycle.
  assign w_active = rst_n && !bus.flush;
  assign w_full   = (r_level == DEPTH_LVL);
  assign w_empty  = (r_level == '0);

  assign w_pop    = w_active && bus.rd_req && (r_state == team_06_audio_pkg::PLAY) && !w_empty;
  // A full buffer still accepts a write when a pop frees a slot this cycle.
  assign w_push   = w_active && bus.wr_valid && (!w_full || w_pop);
  assign w_drop   = w_active && bus.wr_valid && !w_push;
  assign w_starve = w_active && bus.rd_req && (r_state == team_06_audio_pkg::PLAY) && w_empty;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  team_06_sample_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wp),
    .i_wdata (bus.wr_data),
    .i_re    (w_pop),
    .i_raddr (r_rp),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp          <= '0;
      r_rp          <= '0;
      r_level       <= '0;
      r_state       <= team_06_audio_pkg::PRIME;
      r_rd_valid    <= 1'b0;
      r_overrun     <= 1'b0;
      r_underrun    <= 1'b0;
      r_use_silence <= 1'b1;
    end else if (bus.flush) begin
      // r_use_silence is left alone so rd_data keeps its last value.
      r_wp       <= '0;
      r_rp       <= '0;
      r_level    <= '0;
      r_state    <= team_06_audio_pkg::PRIME;
      r_rd_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_req;
      r_overrun  <= w_drop;
      r_underrun <= w_starve;
      if (bus.rd_req) r_use_silence <= !w_pop;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_level <= w_level_nxt;
      case (r_state)
        team_06_audio_pkg::PRIME:
          if (r_level >= PRIME_LVL) r_state <= team_06_audio_pkg::PLAY;
        team_06_audio_pkg::PLAY:
          if (w_starve) r_state <= team_06_audio_pkg::PRIME;
        default:
          r_state <= team_06_audio_pkg::PRIME;
      endcase
    end
  end

  // Both mux inputs are registers, so rd_data changes only at the clock edge.
  assign bus.rd_data  = r_use_silence ? SILENCE : w_ram_q;
  assign bus.rd_valid = r_rd_valid;
  assign bus.level    = r_level;
  assign bus.playing  = (r_state == team_06_audio_pkg::PLAY);
  assign bus.overrun  = r_overrun;
  assign bus.underrun = r_underrun;

endmodule
